// File: rtl/mfp_als_spi_pkg.sv
// Shared frame layout and FSM encoding for the ambient-light-sensor SPI link.
// The SPI master uses the same constants to locate the data bits in a frame.
package mfp_als_spi_pkg;

  localparam int unsigned LeadZeros = 3;   // zero bits sent before the sample
  localparam int unsigned DataWidth = 8;   // light sample width
  localparam int unsigned FrameBits = 16;  // total bits per frame

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StTail  = 2'd2
  } state_e;

  // Number of zero bits that follow the sample in a frame.
  function automatic int unsigned trail_zeros(input int unsigned frame_bits,
                                              input int unsigned lead_zeros,
                                              input int unsigned data_width);
    return frame_bits - lead_zeros - data_width;
  endfunction

endpackage

// File: rtl/mfp_sync_edge_detect.sv
// Multi-flop synchronizer plus edge detector for one asynchronous input.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   din       asynchronous input pin
//   level     synchronized level (aligned with the pulses)
//   rise/fall single-cycle pulses, SYNC_STAGES+1 clocks after the pin edge
module mfp_sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset to the pin's idle level so no edge is reported after reset.
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      last_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~last_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & last_q;
    end
  end

  assign level = last_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/mfp_als_spi_responder.sv
// Sensor-side SPI responder emulating the PmodALS ADC frame:
//   {LEAD_ZEROS zeros, hold value, trailing zeros}, MSB first, driven after SCK falls.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   spi_cs_n      chip select (active-low, async)
//   spi_sck       serial clock (CPOL=0, async)
//   spi_sdo       serial data out
//   sample_data   new light value, loaded when sample_valid is high
//   busy          frame in progress
//   frame_done    pulse: CS released after a complete frame
//   frame_abort   pulse: CS released before the frame completed
module mfp_als_spi_responder
  import mfp_als_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LEAD_ZEROS  = LeadZeros,
  parameter int unsigned DATA_WIDTH  = DataWidth,
  parameter int unsigned FRAME_BITS  = FrameBits
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_cs_n,
  input  logic                  spi_sck,
  output logic                  spi_sdo,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  sample_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_abort
);

  localparam int unsigned TrailZeros = trail_zeros(FRAME_BITS, LEAD_ZEROS, DATA_WIDTH);
  localparam int unsigned CntWidth   = $clog2(FRAME_BITS + 1);
  localparam logic [CntWidth-1:0] LastBit = CntWidth'(FRAME_BITS - 1);

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic unused_sync;

  mfp_sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_sync_cs (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_cs_n),
    .level(cs_level),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  mfp_sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sync_sck (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_sck),
    .level(sck_level),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // Only the CS edges and the SCK falling edge drive the protocol.
  assign unused_sync = ^{cs_level, sck_level, sck_rise};

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_q;
  logic [FRAME_BITS-1:0]   sr_q, sr_d, sr_load;
  logic [CntWidth-1:0]     bit_cnt_q, bit_cnt_d;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;

  assign sr_load = FRAME_BITS'(hold_q) << TrailZeros;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      // A load coinciding with cs_fall lands after the snapshot, so it feeds the next frame.
      if (sample_valid) begin
        hold_q <= sample_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        if (cs_fall) begin
          sr_d    = sr_load;
          state_d = StShift;
        end
      end
      StShift: begin
        // CS release takes priority over a coincident SCK fall.
        if (cs_rise) begin
          abort_d   = 1'b1;
          bit_cnt_d = '0;
          state_d   = StIdle;
        end else if (sck_fall) begin
          sr_d      = {sr_q[FRAME_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_d == LastBit) begin
            state_d = StTail;
          end
        end
      end
      StTail: begin
        // bit_cnt holds at its last value; extra SCK edges are ignored.
        if (cs_rise) begin
          done_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign spi_sdo     = (state_q == StShift) & sr_q[FRAME_BITS-1];
  assign busy        = (state_q != StIdle);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_mfp_als_spi_responder.sv
module tb_mfp_als_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_cs_n;
  logic       spi_sck;
  logic       spi_sdo;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       busy;
  logic       frame_done;
  logic       frame_abort;

  mfp_als_spi_responder dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_sdo     (spi_sdo),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  logic [7:0] hold_m;
  logic       exp_q[$];

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n rising edges, then step just past the edge to drive or sample.
  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    sample_data  = v;
    sample_valid = 1'b1;
    clk_wait(1);
    sample_valid = 1'b0;
    hold_m       = v;
  endtask

  // Master-side frame: SCK = clk/16, reads SDO as it raises SCK.
  task automatic run_frame(input string name, input int nbits, input bit sv_same,
                           input logic [7:0] sv_val, input bit release_cs);
    logic [15:0] word;
    logic        exp_bit;
    word = {3'b000, hold_m, 5'b00000};
    for (int k = 0; k < nbits; k++) exp_q.push_back((k < 16) ? word[15 - k] : 1'b0);
    spi_cs_n = 1'b0;
    if (sv_same) begin
      // cs_fall reaches the FSM on the 4th edge after the pin change.
      clk_wait(3);
      sample_data  = sv_val;
      sample_valid = 1'b1;
      clk_wait(1);
      sample_valid = 1'b0;
      hold_m       = sv_val;
      clk_wait(4);
    end else begin
      clk_wait(8);
    end
    check_eq({name, "_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < nbits; k++) begin
      exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      check_eq($sformatf("%s_bit%0d", name, k), 32'(spi_sdo), 32'(exp_bit));
      spi_sck = 1'b1;
      clk_wait(8);
      spi_sck = 1'b0;
      clk_wait(8);
    end
    if (release_cs) begin
      spi_cs_n = 1'b1;
      clk_wait(8);
    end
  endtask

  int d0, a0;

  initial begin
    rst          = 1'b1;
    spi_cs_n     = 1'b1;
    spi_sck      = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 8'h00;
    hold_m       = 8'h00;
    clk_wait(3);
    rst = 1'b0;
    clk_wait(1);
    check_eq("rst_sdo", 32'(spi_sdo), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_abort", 32'(frame_abort), 32'd0);

    // 1: basic frame with 0xA5
    load(8'hA5);
    d0 = done_cnt; a0 = abort_cnt;
    run_frame("t1", 16, 1'b0, 8'h00, 1'b1);
    check_eq("t1_done", 32'(done_cnt - d0), 32'd1);
    check_eq("t1_abort", 32'(abort_cnt - a0), 32'd0);
    check_eq("t1_busy_end", 32'(busy), 32'd0);

    // 2: load coinciding with cs_fall keeps the old value for this frame
    load(8'hFF);
    run_frame("t2a", 16, 1'b1, 8'h3C, 1'b1);
    run_frame("t2b", 16, 1'b0, 8'h00, 1'b1);

    // 3: early CS release
    load(8'h5A);
    d0 = done_cnt; a0 = abort_cnt;
    run_frame("t3a", 7, 1'b0, 8'h00, 1'b1);
    check_eq("t3_abort", 32'(abort_cnt - a0), 32'd1);
    check_eq("t3_done", 32'(done_cnt - d0), 32'd0);
    check_eq("t3_sdo_idle", 32'(spi_sdo), 32'd0);
    check_eq("t3_busy_idle", 32'(busy), 32'd0);
    run_frame("t3b", 16, 1'b0, 8'h00, 1'b1);

    // 4: 20 SCK edges in one CS window
    load(8'h81);
    d0 = done_cnt; a0 = abort_cnt;
    run_frame("t4", 20, 1'b0, 8'h00, 1'b0);
    check_eq("t4_bitcnt", 32'(dut.bit_cnt_q), 32'd15);
    spi_cs_n = 1'b1;
    clk_wait(8);
    check_eq("t4_done", 32'(done_cnt - d0), 32'd1);
    check_eq("t4_abort", 32'(abort_cnt - a0), 32'd0);

    // 5: reset mid-frame
    load(8'hC3);
    d0 = done_cnt; a0 = abort_cnt;
    run_frame("t5a", 5, 1'b0, 8'h00, 1'b0);
    rst      = 1'b1;
    spi_cs_n = 1'b1;
    clk_wait(1);
    rst = 1'b0;
    check_eq("t5_sdo", 32'(spi_sdo), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_done_lvl", 32'(frame_done), 32'd0);
    check_eq("t5_abort_lvl", 32'(frame_abort), 32'd0);
    clk_wait(10);
    check_eq("t5_no_pulse", 32'((done_cnt - d0) + (abort_cnt - a0)), 32'd0);
    hold_m = 8'h00;
    run_frame("t5b", 16, 1'b0, 8'h00, 1'b1);

    // 6: SCK activity with CS high
    d0 = done_cnt; a0 = abort_cnt;
    for (int k = 0; k < 10; k++) begin
      spi_sck = 1'b1;
      clk_wait(8);
      check_eq($sformatf("t6_sdo%0d", k), 32'(spi_sdo), 32'd0);
      check_eq($sformatf("t6_busy%0d", k), 32'(busy), 32'd0);
      spi_sck = 1'b0;
      clk_wait(8);
    end
    check_eq("t6_no_pulse", 32'((done_cnt - d0) + (abort_cnt - a0)), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
